// File: rtl/fu_sched_pkg.sv
// fu_sched_pkg: shared types for the function-unit scheduler.
//   FU_* : bit positions in the one-hot FU field and in fu_ready
//   div_state_t : divider sequencer states
package fu_sched_pkg;

   localparam int unsigned NFU      = 5;
   localparam int unsigned FU_ALU   = 0;
   localparam int unsigned FU_MEM   = 1;
   localparam int unsigned FU_MUL   = 2;
   localparam int unsigned FU_DIV   = 3;
   localparam int unsigned FU_CSR   = 4;

   localparam int unsigned OPID_W   = 16;
   localparam int unsigned OPID_VLD = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/fu_sched_lwb_pipe.sv
// lwb_pipe: multiplier occupancy shift register for the long writeback port
// and the divider grant derived from it.
//   clk, rst       : clock, async active-low reset
//   mul_fire       : a MUL op issued this cycle
//   div_rdy        : divider result waiting (DONE and not being squashed)
//   mp_empty       : no MUL in flight now
//   mp_empty_nxt   : no MUL in flight next cycle
//   grant          : divider owns the long writeback port this cycle
module lwb_pipe #(
   parameter int unsigned MUL_LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic mul_fire,
   input  logic div_rdy,
   output logic mp_empty,
   output logic mp_empty_nxt,
   output logic grant
);

   logic [MUL_LAT-1:0] mpipe_q, mpipe_d;

   // Bit 0 takes this cycle's MUL fire; the top bit is the writeback slot.
   always_comb begin
      mpipe_d = {mpipe_q[MUL_LAT-2:0], mul_fire};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mpipe_q <= '0;
      else      mpipe_q <= mpipe_d;
   end

   assign mp_empty     = (mpipe_q == '0);
   assign mp_empty_nxt = (mpipe_d == '0);
   // Divider waits for all in-flight MULs; MUL issue is blocked while it
   // waits, so the wait is bounded by MUL_LAT cycles.
   assign grant        = div_rdy & mp_empty;

endmodule

// File: rtl/fu_sched.sv
// fu_sched: function-unit scheduler for the issue stage.
//   iss_fire/iss_fu/iss_opid : per-port issue fire, one-hot FU, opid (bit 15 valid)
//   red_opid/red_topid       : redirect opid (bit 15 valid) and tail opid
//   lsu_release              : memory credits returned this cycle
//   div_done, rob_empty      : divider result level, ROB drained
//   fu_ready                 : registered per-FU ready vector
//   div_start/div_abort      : registered one-cycle divider pulses
//   lwb_div_grant            : combinational divider writeback grant
//   err                      : sticky protocol-violation flag
// Optional: FU_SCHED_STATS_EN adds stall_cnt (per-FU not-ready cycle counters).
module fu_sched
   import fu_sched_pkg::*;
#(
   parameter int unsigned iwd      = 2,
   parameter int unsigned opsz     = 32,
   parameter int unsigned MUL_LAT  = 3,
   parameter int unsigned MEM_CRED = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [iwd-1:0]                 iss_fire,
   input  logic [iwd-1:0][NFU-1:0]        iss_fu,
   input  logic [iwd-1:0][OPID_W-1:0]     iss_opid,
   input  logic [OPID_W-1:0]              red_opid,
   input  logic [OPID_W-1:0]              red_topid,
   input  logic [$clog2(iwd+1)-1:0]       lsu_release,
   input  logic                           div_done,
   input  logic                           rob_empty,
   output logic [NFU-1:0]                 fu_ready,
   output logic                           div_start,
   output logic                           div_abort,
   output logic                           lwb_div_grant,
   output logic                           err
`ifdef FU_SCHED_STATS_EN
   ,
   output logic [NFU-1:0][31:0]           stall_cnt
`endif
);

   localparam int unsigned AW  = $clog2(opsz);
   localparam int unsigned RW  = $clog2(iwd + 1);
   localparam int unsigned CRW = $clog2(MEM_CRED + 1);
   localparam int unsigned CW  = $clog2(MEM_CRED + iwd + 1) + 1;

   div_state_t      state_q, state_d;
   logic [AW-1:0]   div_id_q, div_id_d;
   logic            div_vld_q, div_vld_d;
   logic [CRW-1:0]  cred_q, cred_d;
   logic [NFU-1:0]  fu_ready_q, fu_ready_d;
   logic            div_start_q, div_start_d;
   logic            div_abort_q, div_abort_d;
   logic            err_q, err_d;

   logic [RW-1:0]   n_mem, n_mul, n_div;
   logic [AW-1:0]   pick_id;
   logic            pick_vld;
   logic [CW-1:0]   cred_sum;
   logic            mem_err, squash, mul_fire, div_rdy;
   logic            mp_empty, mp_empty_nxt, grant;
   logic            unused_bits;

   // True when op is strictly younger than the redirect point (tail-relative).
   function automatic logic younger(input logic [AW-1:0] op,
                                    input logic [AW-1:0] red,
                                    input logic [AW-1:0] top);
      logic [AW-1:0] a, b;
      a = op - top;
      b = red - top + AW'(1);
      return a >= b;
   endfunction

   // Per-FU fire counts; lowest DIV port wins the opid latch.
   always_comb begin
      n_mem    = '0;
      n_mul    = '0;
      n_div    = '0;
      pick_id  = '0;
      pick_vld = 1'b0;
      for (int i = int'(iwd) - 1; i >= 0; i--) begin
         if (iss_fire[i] && iss_fu[i][FU_MEM]) n_mem = n_mem + RW'(1);
         if (iss_fire[i] && iss_fu[i][FU_MUL]) n_mul = n_mul + RW'(1);
         if (iss_fire[i] && iss_fu[i][FU_DIV]) begin
            n_div    = n_div + RW'(1);
            pick_id  = iss_opid[i][AW-1:0];
            pick_vld = iss_opid[i][OPID_VLD];
         end
      end
   end

   assign mul_fire = (n_mul != '0);

   // Memory credits with clamping on under/overflow.
   always_comb begin
      mem_err  = 1'b0;
      cred_sum = CW'(cred_q) + CW'(lsu_release);
      if (cred_sum < CW'(n_mem)) begin
         mem_err = 1'b1;
         cred_d  = '0;
      end else if ((cred_sum - CW'(n_mem)) > CW'(MEM_CRED)) begin
         mem_err = 1'b1;
         cred_d  = CRW'(MEM_CRED);
      end else begin
         cred_d  = CRW'(cred_sum - CW'(n_mem));
      end
   end

   assign squash  = (state_q != IDLE) && red_opid[OPID_VLD] && div_vld_q &&
                    younger(div_id_q, red_opid[AW-1:0], red_topid[AW-1:0]);
   assign div_rdy = (state_q == DONE) && !squash;

   lwb_pipe #(.MUL_LAT(MUL_LAT)) u_lwb_pipe (
      .clk          (clk),
      .rst          (rst),
      .mul_fire     (mul_fire),
      .div_rdy      (div_rdy),
      .mp_empty     (mp_empty),
      .mp_empty_nxt (mp_empty_nxt),
      .grant        (grant)
   );

   // Divider sequencer; squash outranks both div_done and the grant.
   always_comb begin
      state_d     = state_q;
      div_id_d    = div_id_q;
      div_vld_d   = div_vld_q;
      div_start_d = 1'b0;
      div_abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (n_div != '0) begin
               state_d     = BUSY;
               div_id_d    = pick_id;
               div_vld_d   = pick_vld;
               div_start_d = 1'b1;
            end
         end
         BUSY: begin
            if (squash) begin
               state_d     = IDLE;
               div_abort_d = 1'b1;
            end else if (div_done) begin
               state_d     = DONE;
            end
         end
         DONE: begin
            if (squash) begin
               state_d     = IDLE;
               div_abort_d = 1'b1;
            end else if (grant) begin
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky error and next-state-based ready vector.
   always_comb begin
      err_d = err_q | mem_err | (n_mul > RW'(1)) | (n_div > RW'(1)) |
              ((n_div != '0) && (state_q != IDLE));
      fu_ready_d         = '0;
      fu_ready_d[FU_ALU] = 1'b1;
      fu_ready_d[FU_MEM] = (cred_d >= CRW'(iwd));
      fu_ready_d[FU_MUL] = (state_d != DONE);
      fu_ready_d[FU_DIV] = (state_d == IDLE);
      fu_ready_d[FU_CSR] = rob_empty && (state_d == IDLE) && mp_empty_nxt &&
                           (cred_d == CRW'(MEM_CRED)) && (iss_fire == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         div_id_q    <= '0;
         div_vld_q   <= 1'b0;
         cred_q      <= CRW'(MEM_CRED);
         fu_ready_q  <= '0;
         div_start_q <= 1'b0;
         div_abort_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_id_q    <= div_id_d;
         div_vld_q   <= div_vld_d;
         cred_q      <= cred_d;
         fu_ready_q  <= fu_ready_d;
         div_start_q <= div_start_d;
         div_abort_q <= div_abort_d;
         err_q       <= err_d;
      end
   end

   assign fu_ready      = fu_ready_q;
   assign div_start     = div_start_q;
   assign div_abort     = div_abort_q;
   assign err           = err_q;
   assign lwb_div_grant = grant;

   // Only the age-compare bits of the opid buses and some FU bits matter here.
   assign unused_bits = ^{iss_opid, iss_fu, red_opid, red_topid};

`ifdef FU_SCHED_STATS_EN
   logic [NFU-1:0][31:0] stall_cnt_q, stall_cnt_d;

   // Per-FU count of cycles spent not ready; wraps naturally.
   always_comb begin
      for (int i = 0; i < int'(NFU); i++) begin
         stall_cnt_d[i] = stall_cnt_q[i] + (fu_ready_q[i] ? 32'd0 : 32'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
